// File: rtl/inst_rom_loader.sv
// Instruction ROM for the openmips fetch port, with a streaming program loader.
// The core is held in reset while a new image is written, then released after HOLD_CYC cycles.
module inst_rom_loader #(
  parameter int ADDR_W   = 10,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [31:0]       inst_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic [ADDR_W:0]   ld_count_o,
  output logic              ld_full_o,
  output logic              ld_done_o,
  output logic              cpu_rst_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [7:0]      HOLD_INIT = 8'(HOLD_CYC - 1);

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            full_q, full_d;
  logic [7:0]      hold_q, hold_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            beat_s;
  logic            in_range_s;
  logic            addr_unused_s;
  logic [31:0]     mem_q [0:DEPTH-1];

  assign beat_s        = ready_q && ld_valid_i;
  assign addr_unused_s = ^addr_i[1:0];

  // Next-state logic; cnt doubles as the write pointer for the current load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (ld_start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          full_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (beat_s) begin
          cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
          if (cnt_q == LAST_IDX) begin
            state_d = S_HOLD;
            full_d  = 1'b1;
            hold_d  = HOLD_INIT;
          end else if (ld_last_i) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_HOLD: begin
        if (ld_start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          full_d  = 1'b0;
        end else if (hold_q == 8'd0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_RUN: begin
        if (ld_start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          full_d  = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change together with the state register.
  always_comb begin
    ready_d   = (state_d == S_LOAD);
    done_d    = (state_d == S_RUN);
    cpu_rst_d = (state_d != S_RUN);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      hold_q    <= 8'd0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Program memory; deliberately not cleared by reset so a loaded image survives it.
  always_ff @(posedge clk) begin
    if (beat_s && !rst) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= ld_data_i;
    end
  end

  assign in_range_s = (addr_i[31:ADDR_W+2] == '0);

  // Zero-latency fetch; anything outside RUN or out of range reads as a nop.
  always_comb begin
    if (ce_i && (state_q == S_RUN) && in_range_s) begin
      inst_o = mem_q[addr_i[ADDR_W+1:2]];
    end else begin
      inst_o = 32'h0;
    end
  end

  assign ld_ready_o = ready_q;
  assign ld_count_o = cnt_q;
  assign ld_full_o  = full_q;
  assign ld_done_o  = done_q;
  assign cpu_rst_o  = cpu_rst_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: a 1K-word instance for load/fetch/restart
// scenarios and a 16-word instance for the memory-full termination.
module tb_inst_rom_loader;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        ld_start, ld_valid, ld_last;
  logic [31:0] ld_data;
  logic        ld_ready, ld_full, ld_done, cpu_rst;
  logic [10:0] ld_count;

  logic        b_ce;
  logic [31:0] b_addr;
  logic [31:0] b_inst;
  logic        b_start, b_valid, b_last;
  logic [31:0] b_data;
  logic        b_ready, b_full, b_done, b_cpu_rst;
  logic [4:0]  b_count;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] model_a [0:1023];
  logic [31:0] model_b [0:15];
  logic [31:0] stim [0:15];
  int          wmax = 0;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(10), .HOLD_CYC(HOLD)) dut_a (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst),
    .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(ld_ready), .ld_count_o(ld_count), .ld_full_o(ld_full),
    .ld_done_o(ld_done), .cpu_rst_o(cpu_rst)
  );

  inst_rom_loader #(.ADDR_W(4), .HOLD_CYC(HOLD)) dut_b (
    .clk(clk), .rst(rst), .ce_i(b_ce), .addr_i(b_addr), .inst_o(b_inst),
    .ld_start_i(b_start), .ld_valid_i(b_valid), .ld_data_i(b_data), .ld_last_i(b_last),
    .ld_ready_o(b_ready), .ld_count_o(b_count), .ld_full_o(b_full),
    .ld_done_o(b_done), .cpu_rst_o(b_cpu_rst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference fetch: the byte address selects a word; beyond 4 KiB or outside RUN it is a nop.
  function automatic logic [31:0] ref_fetch(input logic ce_v, input logic [31:0] a, input bit running);
    if (ce_v && running && a < 32'd4096) return model_a[a >> 2];
    else return 32'h0;
  endfunction

  task automatic fetch_chk(input string tag, input logic ce_v, input logic [31:0] a, input bit running);
    ce = ce_v;
    addr = a;
    #1;
    chk(tag, {32'h0, inst}, {32'h0, ref_fetch(ce_v, a, running)});
    tick();
  endtask

  // Starts a load of n words from stim[]; with gaps, idle cycles carry a stray ld_last.
  task automatic do_load(input int n, input bit gaps);
    int i;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("start_ready", {63'h0, ld_ready}, 64'd1);
    chk("start_cpu_rst", {63'h0, cpu_rst}, 64'd1);
    chk("start_count", {53'h0, ld_count}, 64'd0);
    ce = 1'b1;
    addr = 32'h0;
    #1;
    chk("start_fetch_nop", {32'h0, inst}, 64'd0);
    i = 0;
    while (i < n) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        ld_valid = 1'b0;
        ld_last  = 1'($urandom_range(0, 1));
        ld_data  = $urandom;
        tick();
        chk("gap_count", {53'h0, ld_count}, 64'(i));
        chk("gap_ready", {63'h0, ld_ready}, 64'd1);
      end else begin
        ld_valid = 1'b1;
        ld_data  = stim[i];
        ld_last  = (i == n - 1);
        tick();
        model_a[i] = stim[i];
        i++;
        chk("beat_count", {53'h0, ld_count}, 64'(i));
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (n > wmax) wmax = n;
    for (int k = 1; k <= HOLD; k++) begin
      chk("hold_cpu_rst", {63'h0, cpu_rst}, 64'd1);
      chk("hold_ready", {63'h0, ld_ready}, 64'd0);
      tick();
    end
    chk("run_cpu_rst", {63'h0, cpu_rst}, 64'd0);
    chk("run_done", {63'h0, ld_done}, 64'd1);
    chk("run_full", {63'h0, ld_full}, 64'd0);
    chk("run_count", {53'h0, ld_count}, 64'(n));
  endtask

  task automatic random_fetches(input int cnt);
    logic [31:0] a;
    for (int j = 0; j < cnt; j++) begin
      if ($urandom_range(0, 3) == 0) a = 32'h1000 + $urandom_range(0, 32'hFFFF);
      else a = 32'($urandom_range(0, wmax - 1) * 4 + $urandom_range(0, 3));
      fetch_chk("rand_fetch", 1'($urandom_range(0, 3) != 0), a, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; addr = 32'h0;
    ld_start = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'h0;
    b_ce = 1'b0; b_addr = 32'h0; b_start = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_data = 32'h0;

    // Reset with ld_start held high: reset must win.
    tick();
    tick();
    rst = 1'b0;
    ld_start = 1'b0;
    chk("rst_cpu_rst", {63'h0, cpu_rst}, 64'd1);
    chk("rst_ready", {63'h0, ld_ready}, 64'd0);
    chk("rst_count", {53'h0, ld_count}, 64'd0);
    chk("rst_done", {63'h0, ld_done}, 64'd0);
    chk("rst_full", {63'h0, ld_full}, 64'd0);
    fetch_chk("rst_fetch", 1'b1, 32'h0, 1'b0);

    // Basic three-word load.
    stim[0] = 32'h34011100; stim[1] = 32'h34020020; stim[2] = 32'h3403ff00;
    do_load(3, 1'b0);
    fetch_chk("basic_addr8", 1'b1, 32'd8, 1'b1);
    chk("basic_word2", {32'h0, model_a[2]}, 64'h3403ff00);
    fetch_chk("basic_ce0", 1'b0, 32'd4, 1'b1);
    fetch_chk("basic_addr1", 1'b1, 32'd1, 1'b1);

    // Backpressure: ten random words with random valid gaps (restart from RUN).
    for (int j = 0; j < 10; j++) stim[j] = $urandom;
    do_load(10, 1'b1);
    for (int j = 0; j < 10; j++) fetch_chk("bp_readback", 1'b1, 32'(j * 4), 1'b1);
    random_fetches(20);

    // Restart from RUN with a one-word image, then out-of-range fetch.
    stim[0] = $urandom;
    do_load(1, 1'b0);
    fetch_chk("reload_word0", 1'b1, 32'h0, 1'b1);
    fetch_chk("reload_word1_old", 1'b1, 32'h4, 1'b1);
    fetch_chk("range_0x1000", 1'b1, 32'h0000_1000, 1'b1);

    // Reset after two of five beats.
    for (int j = 0; j < 5; j++) stim[j] = $urandom;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      ld_valid = 1'b1; ld_data = stim[j]; ld_last = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", {53'h0, ld_count}, 64'd0);
    chk("midrst_ready", {63'h0, ld_ready}, 64'd0);
    chk("midrst_cpu_rst", {63'h0, cpu_rst}, 64'd1);
    fetch_chk("midrst_fetch", 1'b1, 32'h0, 1'b0);
    do_load(5, 1'b0);
    for (int j = 0; j < 5; j++) fetch_chk("midrst_readback", 1'b1, 32'(j * 4), 1'b1);

    // Fill a 16-word memory with no ld_last; the final word ends the load.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("fill_ready", {63'h0, b_ready}, 64'd1);
      chk("fill_full_pre", {63'h0, b_full}, 64'd0);
      model_b[j] = $urandom;
      b_valid = 1'b1; b_data = model_b[j]; b_last = 1'b0;
      tick();
    end
    b_valid = 1'b0;
    chk("fill_full", {63'h0, b_full}, 64'd1);
    chk("fill_count", {59'h0, b_count}, 64'd16);
    chk("fill_ready_off", {63'h0, b_ready}, 64'd0);
    chk("fill_cpu_rst", {63'h0, b_cpu_rst}, 64'd1);
    for (int k = 0; k < HOLD; k++) tick();
    chk("fill_run", {63'h0, b_done}, 64'd1);
    for (int j = 0; j < 16; j++) begin
      b_ce = 1'b1;
      b_addr = 32'(j * 4);
      #1;
      chk("fill_readback", {32'h0, b_inst}, {32'h0, model_b[j]});
      tick();
    end
    b_addr = 32'h40;
    #1;
    chk("fill_out_of_range", {32'h0, b_inst}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
